// File: rtl/alu_issue_stage_pkg.sv
// Shared types and RV32I field constants for the ALU issue stage.
package lucknow_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SRA = 3'b111
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream and downstream handshake bundle of the ALU issue stage.
interface alu_issue_if #(parameter int DATA_WIDTH = 32);
  import lucknow_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [6:0]            in_opcode;
  logic [2:0]            in_funct3;
  logic [6:0]            in_funct7;
  logic [DATA_WIDTH-1:0] in_rs1_data;
  logic [DATA_WIDTH-1:0] in_rs2_data;
  logic [DATA_WIDTH-1:0] in_imm;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [4:0]            in_rd;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_a;
  logic [DATA_WIDTH-1:0] out_b;
  alu_op_e               out_alu_op;
  logic [4:0]            out_rd;
  logic                  out_illegal;

  // master: the environment around the stage; slave: the stage itself
  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7, in_rs1_data, in_rs2_data,
           in_imm, in_pc, in_rd, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_alu_op, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7, in_rs1_data, in_rs2_data,
           in_imm, in_pc, in_rd, out_ready,
    output in_ready, out_valid, out_a, out_b, out_alu_op, out_rd, out_illegal
  );

endinterface

// File: rtl/alu_issue_stage_decode.sv
// Combinational RV32I field decode into ALU op and operand selection.
module alu_op_decode
  import lucknow_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [6:0]            i_opcode,
  input  logic [2:0]            i_funct3,
  input  logic [6:0]            i_funct7,
  input  logic [DATA_WIDTH-1:0] i_rs1,
  input  logic [DATA_WIDTH-1:0] i_rs2,
  input  logic [DATA_WIDTH-1:0] i_imm,
  input  logic [DATA_WIDTH-1:0] i_pc,
  output alu_op_e               o_op,
  output logic [DATA_WIDTH-1:0] o_a,
  output logic [DATA_WIDTH-1:0] o_b,
  output logic                  o_illegal
);

  logic w_is_imm;
  logic w_f7_base;

  assign w_is_imm  = (i_opcode == OPC_OP_IMM);
  assign w_f7_base = (i_funct7 == F7_BASE);

  always_comb begin
    o_op      = ALU_ADD;
    o_a       = '0;
    o_b       = '0;
    o_illegal = 1'b1;
    case (i_opcode)
      OPC_OP, OPC_OP_IMM: begin
        o_illegal = 1'b0;
        // OP-IMM logical ops carry immediate bits in funct7, so only OP checks it
        case (i_funct3)
          3'b000: begin
            if (!w_is_imm && i_funct7 == F7_ALT) o_op = ALU_SUB;
            else if (!w_is_imm && !w_f7_base)    o_illegal = 1'b1;
          end
          3'b111: begin
            o_op      = ALU_AND;
            o_illegal = !w_is_imm && !w_f7_base;
          end
          3'b110: begin
            o_op      = ALU_OR;
            o_illegal = !w_is_imm && !w_f7_base;
          end
          3'b100: begin
            o_op      = ALU_XOR;
            o_illegal = !w_is_imm && !w_f7_base;
          end
          3'b001: begin
            o_op      = ALU_SLL;
            o_illegal = !w_f7_base;
          end
          3'b101: begin
            if (w_f7_base)                o_op = ALU_SRL;
            else if (i_funct7 == F7_ALT)  o_op = ALU_SRA;
            else                          o_illegal = 1'b1;
          end
          default: o_illegal = 1'b1;
        endcase
        o_a = i_rs1;
        o_b = w_is_imm ? i_imm : i_rs2;
      end
      OPC_LOAD, OPC_STORE: begin
        o_illegal = 1'b0;
        o_a       = i_rs1;
        o_b       = i_imm;
      end
      OPC_LUI: begin
        o_illegal = 1'b0;
        o_b       = i_imm;
      end
      OPC_AUIPC: begin
        o_illegal = 1'b0;
        o_a       = i_pc;
        o_b       = i_imm;
      end
      default: o_illegal = 1'b1;
    endcase
    // Illegal bundles travel as a harmless ADD of zeros
    if (o_illegal) begin
      o_op = ALU_ADD;
      o_a  = '0;
      o_b  = '0;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode plus a two-entry skid buffer with registered in_ready.
module alu_issue_stage
  import lucknow_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  alu_issue_if.slave bus
);

  typedef struct packed {
    alu_op_e               op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [4:0]            rd;
    logic                  illegal;
  } bundle_t;

  alu_op_e               w_op;
  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;
  logic                  w_illegal;
  bundle_t               w_dec;
  logic                  w_in_fire;
  logic                  w_out_free;

  bundle_t r_out;
  bundle_t r_skid;
  logic    r_out_valid;
  logic    r_skid_valid;
  logic    r_in_ready;

  alu_op_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .i_opcode  (bus.in_opcode),
    .i_funct3  (bus.in_funct3),
    .i_funct7  (bus.in_funct7),
    .i_rs1     (bus.in_rs1_data),
    .i_rs2     (bus.in_rs2_data),
    .i_imm     (bus.in_imm),
    .i_pc      (bus.in_pc),
    .o_op      (w_op),
    .o_a       (w_a),
    .o_b       (w_b),
    .o_illegal (w_illegal)
  );

  assign w_dec      = {w_op, w_a, w_b, bus.in_rd, w_illegal};
  assign w_in_fire  = bus.in_valid & r_in_ready;
  assign w_out_free = ~r_out_valid | bus.out_ready;

  // in_ready is only ever the registered inverse of the next skid occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_out_free) begin
      r_in_ready <= 1'b1;
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_out       <= w_dec;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end else begin
      r_in_ready <= ~r_skid_valid;
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_a       = r_out.a;
  assign bus.out_b       = r_out.b;
  assign bus.out_alu_op  = r_out.op;
  assign bus.out_rd      = r_out.rd;
  assign bus.out_illegal = r_out.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed corner cases plus random traffic
// against a rule-table decode model and an in-order scoreboard.
module tb_alu_issue_stage;
  import lucknow_pkg::*;

  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;

  alu_issue_if #(.DATA_WIDTH(DW)) bus ();

  alu_issue_stage #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  // One legal instruction form: f3/f7 of -1 match anything; aSel 0=rs1 1=pc 2=zero; bSel 0=rs2 1=imm
  typedef struct {
    logic [6:0] opc;
    int         f3;
    int         f7;
    logic [2:0] op;
    int         aSel;
    int         bSel;
  } rule_t;

  rule_t rules[$];
  exp_t  expQ[$];
  int    total    = 0;
  int    bad      = 0;
  int    outCount = 0;

  function automatic void addRule(logic [6:0] opc, int f3, int f7, logic [2:0] op, int aSel, int bSel);
    rule_t r;
    r.opc = opc; r.f3 = f3; r.f7 = f7; r.op = op; r.aSel = aSel; r.bSel = bSel;
    rules.push_back(r);
  endfunction

  task automatic initRules();
    addRule(7'b0110011, 0, 'h00, 3'b000, 0, 0);
    addRule(7'b0110011, 0, 'h20, 3'b001, 0, 0);
    addRule(7'b0110011, 7, 'h00, 3'b010, 0, 0);
    addRule(7'b0110011, 6, 'h00, 3'b011, 0, 0);
    addRule(7'b0110011, 4, 'h00, 3'b100, 0, 0);
    addRule(7'b0110011, 1, 'h00, 3'b101, 0, 0);
    addRule(7'b0110011, 5, 'h00, 3'b110, 0, 0);
    addRule(7'b0110011, 5, 'h20, 3'b111, 0, 0);
    addRule(7'b0010011, 0, -1,   3'b000, 0, 1);
    addRule(7'b0010011, 7, -1,   3'b010, 0, 1);
    addRule(7'b0010011, 6, -1,   3'b011, 0, 1);
    addRule(7'b0010011, 4, -1,   3'b100, 0, 1);
    addRule(7'b0010011, 1, 'h00, 3'b101, 0, 1);
    addRule(7'b0010011, 5, 'h00, 3'b110, 0, 1);
    addRule(7'b0010011, 5, 'h20, 3'b111, 0, 1);
    addRule(7'b0000011, -1, -1,  3'b000, 0, 1);
    addRule(7'b0100011, -1, -1,  3'b000, 0, 1);
    addRule(7'b0110111, -1, -1,  3'b000, 2, 1);
    addRule(7'b0010111, -1, -1,  3'b000, 1, 1);
  endtask

  function automatic exp_t model(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7,
                                 logic [31:0] rs1, logic [31:0] rs2, logic [31:0] imm,
                                 logic [31:0] pc, logic [4:0] rd);
    exp_t e;
    e.op = 3'b000; e.a = 32'd0; e.b = 32'd0; e.rd = rd; e.ill = 1'b1;
    foreach (rules[i]) begin
      if (e.ill && rules[i].opc == opc &&
          (rules[i].f3 < 0 || rules[i].f3 == int'(f3)) &&
          (rules[i].f7 < 0 || rules[i].f7 == int'(f7))) begin
        e.ill = 1'b0;
        e.op  = rules[i].op;
        e.a   = (rules[i].aSel == 0) ? rs1 : (rules[i].aSel == 1) ? pc : 32'd0;
        e.b   = (rules[i].bSel == 0) ? rs2 : imm;
      end
    end
    return e;
  endfunction

  function automatic exp_t mkExp(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] rd, logic ill);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.rd = rd; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t e;
    e.op = bus.out_alu_op; e.a = bus.out_a; e.b = bus.out_b; e.rd = bus.out_rd; e.ill = bus.out_illegal;
    return e;
  endfunction

  task automatic checkOutput(string tag, logic [127:0] obs, logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(logic v, logic [6:0] opc, logic [2:0] f3, logic [6:0] f7,
                               logic [31:0] rs1, logic [31:0] rs2, logic [31:0] imm,
                               logic [31:0] pc, logic [4:0] rd);
    bus.in_valid = v; bus.in_opcode = opc; bus.in_funct3 = f3; bus.in_funct7 = f7;
    bus.in_rs1_data = rs1; bus.in_rs2_data = rs2; bus.in_imm = imm; bus.in_pc = pc; bus.in_rd = rd;
  endtask

  task automatic applyRandom();
    logic [6:0] opc;
    logic [6:0] f7;
    case ($urandom_range(0, 9))
      0, 1, 2: opc = 7'b0110011;
      3, 4, 5: opc = 7'b0010011;
      6:       opc = 7'b0000011;
      7:       opc = 7'b0100011;
      8:       opc = ($urandom_range(0, 1) == 0) ? 7'b0110111 : 7'b0010111;
      default: opc = 7'($urandom());
    endcase
    case ($urandom_range(0, 4))
      0, 1:    f7 = 7'h00;
      2, 3:    f7 = 7'h20;
      default: f7 = 7'($urandom());
    endcase
    applyStimulus(1'b1, opc, 3'($urandom()), f7, $urandom(), $urandom(), $urandom(),
                  $urandom(), 5'($urandom()));
  endtask

  // Inputs are set at the falling edge, so handshakes for the next rising edge are known here
  task automatic tick();
    exp_t e;
    if (rst_n && !flush) begin
      if (bus.out_valid && bus.out_ready) begin
        outCount++;
        checkOutput("out_has_expect", 128'(expQ.size() > 0), 128'(1));
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput("sb_bundle", 128'(observed()), 128'(e));
        end
      end
      if (bus.in_valid && bus.in_ready)
        expQ.push_back(model(bus.in_opcode, bus.in_funct3, bus.in_funct7, bus.in_rs1_data,
                             bus.in_rs2_data, bus.in_imm, bus.in_pc, bus.in_rd));
    end
    if (flush) expQ.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int   startCnt;
    logic lastFire;
    logic heldPrev;
    exp_t heldVal;

    initRules();
    applyStimulus(1'b0, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 128'(bus.out_valid), 128'(0));
    checkOutput("rst_in_ready", 128'(bus.in_ready), 128'(0));
    checkOutput("rst_out_data", 128'(observed()), 128'(0));
    rst_n = 1'b1;
    checkOutput("rel_in_ready_pre", 128'(bus.in_ready), 128'(0));
    tick();
    checkOutput("rel_in_ready", 128'(bus.in_ready), 128'(1));
    checkOutput("rel_out_valid", 128'(bus.out_valid), 128'(0));

    // SUB from OP with funct7 alt
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 7'b0110011, 3'b000, 7'b0100000, 32'd5, 32'd3, 32'h77, 32'h40, 5'd7);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("sub_valid", 128'(bus.out_valid), 128'(1));
    checkOutput("sub_bundle", 128'(observed()), 128'(mkExp(3'b001, 32'd5, 32'd3, 5'd7, 1'b0)));
    tick();
    checkOutput("sub_drained", 128'(bus.out_valid), 128'(0));

    applyStimulus(1'b1, 7'b0010111, 3'b011, 7'h15, 32'hAAAA, 32'hBBBB, 32'h2000, 32'h1000, 5'd3);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("auipc_bundle", 128'(observed()), 128'(mkExp(3'b000, 32'h1000, 32'h2000, 5'd3, 1'b0)));
    tick();

    applyStimulus(1'b1, 7'b0010011, 3'b010, 7'h00, 32'hDEAD, 32'hBEEF, 32'd5, 32'h8, 5'd9);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("slti_illegal", 128'(observed()), 128'(mkExp(3'b000, 32'd0, 32'd0, 5'd9, 1'b1)));
    tick();

    // Three cycles of downstream stall with upstream pushing
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 7'b0110011, 3'b111, 7'h00, 32'd11, 32'd22, 32'd0, 32'd0, 5'd1);
    tick();
    applyStimulus(1'b1, 7'b0110011, 3'b110, 7'h00, 32'd33, 32'd44, 32'd0, 32'd0, 5'd2);
    tick();
    checkOutput("stall_in_ready", 128'(bus.in_ready), 128'(0));
    checkOutput("stall_first_held", 128'(observed()), 128'(mkExp(3'b010, 32'd11, 32'd22, 5'd1, 1'b0)));
    applyStimulus(1'b1, 7'b0010011, 3'b100, 7'h3F, 32'd55, 32'd0, 32'd66, 32'd0, 5'd3);
    tick();
    checkOutput("stall_valid_kept", 128'(bus.out_valid), 128'(1));
    checkOutput("stall_still_first", 128'(observed()), 128'(mkExp(3'b010, 32'd11, 32'd22, 5'd1, 1'b0)));
    checkOutput("stall_in_ready2", 128'(bus.in_ready), 128'(0));
    bus.out_ready = 1'b1;
    tick();
    checkOutput("drain_second", 128'(observed()), 128'(mkExp(3'b011, 32'd33, 32'd44, 5'd2, 1'b0)));
    checkOutput("drain_in_ready", 128'(bus.in_ready), 128'(1));
    tick();
    bus.in_valid = 1'b0;
    checkOutput("drain_third", 128'(observed()), 128'(mkExp(3'b100, 32'd55, 32'd66, 5'd3, 1'b0)));
    tick();
    checkOutput("drain_empty", 128'(bus.out_valid), 128'(0));
    checkOutput("drain_queue", 128'(expQ.size()), 128'(0));

    // Flush with output held and skid full
    bus.out_ready = 1'b0;
    applyRandom();
    tick();
    applyRandom();
    tick();
    applyRandom();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flush_full_valid", 128'(bus.out_valid), 128'(0));
    checkOutput("flush_full_ready", 128'(bus.in_ready), 128'(1));
    bus.out_ready = 1'b1;
    tick();
    checkOutput("flush_full_none", 128'(bus.out_valid), 128'(0));

    // Flush racing an accepted input handshake
    bus.out_ready = 1'b0;
    applyRandom();
    tick();
    applyRandom();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flush_hs_valid", 128'(bus.out_valid), 128'(0));
    checkOutput("flush_hs_ready", 128'(bus.in_ready), 128'(1));
    bus.out_ready = 1'b1;
    tick();
    checkOutput("flush_hs_dropped", 128'(bus.out_valid), 128'(0));

    // Full-rate streaming: 100 bundles must leave within 101 edges
    startCnt = outCount;
    for (int i = 0; i < 101; i++) begin
      if (i < 100) applyRandom();
      else bus.in_valid = 1'b0;
      tick();
    end
    checkOutput("stream_count", 128'(outCount - startCnt), 128'(100));
    checkOutput("stream_queue", 128'(expQ.size()), 128'(0));

    // Random valid/ready traffic with hold-stability checks
    lastFire = 1'b1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!bus.in_valid || lastFire) begin
        if ($urandom_range(0, 3) != 0) applyRandom();
        else bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      lastFire = bus.in_valid && bus.in_ready;
      heldPrev = bus.out_valid && !bus.out_ready;
      heldVal  = observed();
      tick();
      if (heldPrev)
        checkOutput("hold_stable", 128'({bus.out_valid, observed()}), 128'({1'b1, heldVal}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && expQ.size() > 0; i++) tick();
    checkOutput("random_drain", 128'(expQ.size()), 128'(0));

    // Asynchronous reset with the skid full
    bus.out_ready = 1'b0;
    applyRandom();
    tick();
    applyRandom();
    tick();
    checkOutput("prereset_skid_full", 128'(bus.in_ready), 128'(0));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 128'(bus.out_valid), 128'(0));
    checkOutput("async_rst_ready", 128'(bus.in_ready), 128'(0));
    expQ.delete();
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rerel_ready_pre", 128'(bus.in_ready), 128'(0));
    tick();
    checkOutput("rerel_ready", 128'(bus.in_ready), 128'(1));
    checkOutput("rerel_valid", 128'(bus.out_valid), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
